mul_rs: RTL and testbench
=========================

# mul_rs

Reservation station for the multiply unit in the out-of-order core. It accepts renamed MUL/MULH/MULHSU/MULHU instructions from dispatch and holds each one until both source operands are valid. Operand values are captured by snooping the common data bus (CDB). Each cycle it issues the oldest ready entry to the downstream `mul` unit, which is fully pipelined, has no ready signal, and accepts one request per cycle.

## Interface
Parameters:
- DEPTH, 4: number of entries (≥2)
- TAG_W, 6: physical register tag width

Ports:
- clk_i  in  1  clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- flush_i  in  1  pipeline flush (mispredict); discards all entries
- dispatch_valid_i  in  1  dispatch offers an instruction
- dispatch_ready_o  out  1  station can accept (count < DEPTH)
- inst_i  in  32  raw instruction word
- pc_i  in  32  instruction PC
- rd_tag_i  in  TAG_W  destination physical tag
- rs1_tag_i / rs2_tag_i  in  TAG_W  source tags
- rs1_ready_i / rs2_ready_i  in  1  source value already valid at dispatch
- rs1_value_i / rs2_value_i  in  32  source values (meaningful only when the matching ready is 1)
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_value_i  in  32  broadcast value
- mul_request_o  out  1  issue valid to `mul`
- inst_o, pc_o  out  32  issued instruction and PC
- rs1_value_o, rs2_value_o  out  32  issued operands
- rd_tag_o  out  TAG_W  issued destination tag
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage is a collapsing queue. Entry 0 is the oldest. Valid entries are always contiguous from index 0.
- Each entry holds: valid, inst, pc, rd_tag, and per source {tag, ready, value}.
- Dispatch: accepted when dispatch_valid_i && dispatch_ready_o && !flush_i. The entry is written at index count (after the issue shift, if any; see below).
- Dispatch bypass: if cdb_valid_i and cdb_tag_i equals a not-ready source tag of the dispatching instruction in the same cycle, that source is stored ready with cdb_value_i.
- Wakeup: every valid entry compares cdb_tag_i against each not-ready source. On a match with cdb_valid_i, it sets ready and latches cdb_value_i. Ready sources are never overwritten.
- Select: an entry is eligible when valid and both ready flags are set in registered state. The lowest-index eligible entry is selected. Outputs are combinational from that entry.
- mul_request_o = any eligible entry && !flush_i.
- Issue: the selected entry is removed at the clock edge. Entries above it shift down one index.
- A CDB match on a shifting entry is applied to the entry at its new index.
- Simultaneous issue and dispatch: the shift happens first, so the new entry lands at count-1. count_o is unchanged.
- dispatch_ready_o depends only on registered count (count_o < DEPTH). It ignores a same-cycle issue, so there is no combinational path from select.
- Flush: at the edge, all valid bits clear and count becomes 0. A same-cycle dispatch is dropped and mul_request_o is 0.
- Non-MUL-family opcodes are not checked; dispatch guarantees funct7=0000001 and opcode 0110011.

## Timing
- Reset (asynchronous, reset_ni=0): all valid bits = 0, count_o = 0, dispatch_ready_o = 1, mul_request_o = 0. All data outputs = 0 (outputs are muxed to 0 when no entry is eligible).
- Minimum latency: dispatched at edge t with both sources ready → mul_request_o = 1 in the cycle after t.
- Wakeup latency: CDB broadcast in cycle c satisfying the last operand → issue in cycle c+1. There is no same-cycle CDB-to-issue path.
- Throughput: one issue per cycle, one dispatch per cycle.
- Full: count_o = DEPTH → dispatch_ready_o = 0. Readiness returns the cycle after any issue or flush.
- Reset asserted mid-operation discards everything immediately. Outputs go low asynchronously.

## Test plan
- Reset then dispatch mul x1,x2,x3 (inst 0x023100b3, pc 0x4, rs1=0x1, rs2=0xf0000001, both ready, rd_tag 5) → next cycle: mul_request_o=1, inst_o=0x023100b3, pc_o=0x4, rs2_value_o=0xf0000001, rd_tag_o=5. The following cycle: mul_request_o=0, count_o=0.
- Dispatch mulh (0x023110b3) with rs1 tag 7 not ready, rs2=0x2 ready → no issue. CDB tag 7 value 0x2 in cycle c → issue in cycle c+1 with rs1_value_o=0x2.
- Dispatch A (tag 9 pending), then B ready (mulhu 0x023130b3, rs1=rs2=0x3) → B issues first. Broadcast tag 9 → A issues next. Queue order stays intact.
- Dispatch with rs2 tag 12 not ready while CDB broadcasts tag 12 value 0x4 the same cycle → entry captures 0x4 and issues the next cycle.
- Fill DEPTH=4 entries, all pending → dispatch_ready_o=0 and a fifth dispatch is not accepted. Wake entry 2 → it issues, the remaining entries compact, and dispatch_ready_o=1 the next cycle.
- Three entries valid and flush_i pulsed together with dispatch_valid_i → count_o=0 next cycle, no issue, and the dispatched instruction is discarded.

Source files
------------

// File: rtl/mul_rs.sv
// mul_rs: reservation station for the pipelined multiply unit.
// Collapsing queue (entry 0 oldest) that snoops the CDB for operands and
// issues the oldest entry whose sources are both ready.
module mul_rs #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       flush_i,
    input  logic                       dispatch_valid_i,
    output logic                       dispatch_ready_o,
    input  logic [31:0]                inst_i,
    input  logic [31:0]                pc_i,
    input  logic [TAG_W-1:0]           rd_tag_i,
    input  logic [TAG_W-1:0]           rs1_tag_i,
    input  logic [TAG_W-1:0]           rs2_tag_i,
    input  logic                       rs1_ready_i,
    input  logic                       rs2_ready_i,
    input  logic [31:0]                rs1_value_i,
    input  logic [31:0]                rs2_value_i,
    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [31:0]                cdb_value_i,
    output logic                       mul_request_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                rs1_value_o,
    output logic [31:0]                rs2_value_o,
    output logic [TAG_W-1:0]           rd_tag_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    typedef struct packed {
        logic             valid;
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [TAG_W-1:0] rd;
        logic [TAG_W-1:0] t1;
        logic             r1;
        logic [31:0]      v1;
        logic [TAG_W-1:0] t2;
        logic             r2;
        logic [31:0]      v2;
    } entry_t;

    entry_t          ents [DEPTH];
    entry_t          woken [DEPTH];
    entry_t          nxt [DEPTH];
    entry_t          incoming;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   wr_idx;
    logic [IW-1:0]   sel;
    logic            any_elig;
    logic            issue;
    logic            accept;

    assign dispatch_ready_o = (count < CW'(DEPTH));
    assign accept           = dispatch_valid_i && dispatch_ready_o && !flush_i;
    assign issue            = any_elig && !flush_i;
    assign mul_request_o    = issue;
    assign count_o          = count;

    // Oldest-first select over registered ready state; drive outputs from it.
    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!any_elig && ents[i].valid && ents[i].r1 && ents[i].r2) begin
                sel      = IW'(i);
                any_elig = 1'b1;
            end
        end
        inst_o      = '0;
        pc_o        = '0;
        rs1_value_o = '0;
        rs2_value_o = '0;
        rd_tag_o    = '0;
        if (any_elig) begin
            inst_o      = ents[sel].inst;
            pc_o        = ents[sel].pc;
            rs1_value_o = ents[sel].v1;
            rs2_value_o = ents[sel].v2;
            rd_tag_o    = ents[sel].rd;
        end
    end

    // Build the incoming entry, capturing a same-cycle CDB broadcast.
    always_comb begin
        incoming       = '0;
        incoming.valid = 1'b1;
        incoming.inst  = inst_i;
        incoming.pc    = pc_i;
        incoming.rd    = rd_tag_i;
        incoming.t1    = rs1_tag_i;
        incoming.t2    = rs2_tag_i;
        incoming.r1    = rs1_ready_i;
        incoming.v1    = rs1_value_i;
        incoming.r2    = rs2_ready_i;
        incoming.v2    = rs2_value_i;
        if (!rs1_ready_i && cdb_valid_i && cdb_tag_i == rs1_tag_i) begin
            incoming.r1 = 1'b1;
            incoming.v1 = cdb_value_i;
        end
        if (!rs2_ready_i && cdb_valid_i && cdb_tag_i == rs2_tag_i) begin
            incoming.r2 = 1'b1;
            incoming.v2 = cdb_value_i;
        end
    end

    // Wakeup is applied before the collapse so a shifting entry keeps its capture.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woken[i] = ents[i];
            if (ents[i].valid && cdb_valid_i) begin
                if (!ents[i].r1 && cdb_tag_i == ents[i].t1) begin
                    woken[i].r1 = 1'b1;
                    woken[i].v1 = cdb_value_i;
                end
                if (!ents[i].r2 && cdb_tag_i == ents[i].t2) begin
                    woken[i].r2 = 1'b1;
                    woken[i].v2 = cdb_value_i;
                end
            end
        end
    end

    // Collapse above the issued slot, then append the dispatch at the new tail.
    always_comb begin
        wr_idx    = count - CW'(issue);
        count_nxt = wr_idx + CW'(accept);
        for (int unsigned j = 0; j < DEPTH; j++) begin
            nxt[j] = woken[j];
            if (issue && IW'(j) >= sel) begin
                if (j + 1 < DEPTH) begin
                    nxt[j] = woken[j + 1];
                end else begin
                    nxt[j]       = woken[j];
                    nxt[j].valid = 1'b0;
                end
            end
            if (accept && CW'(j) == wr_idx) begin
                nxt[j] = incoming;
            end
        end
    end

    // State register with flush and asynchronous reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ents[i] <= '0;
            end
        end else if (flush_i) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ents[i].valid <= 1'b0;
            end
        end else begin
            count <= count_nxt;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ents[i] <= nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_mul_rs.sv
// Directed self-checking bench for mul_rs.
module tb_mul_rs;

    localparam int unsigned TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset_ni;
    logic             flush;
    logic             dvalid;
    logic             dready;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic             r1;
    logic             r2;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             req;
    logic [31:0]      inst_o;
    logic [31:0]      pc_o;
    logic [31:0]      v1_o;
    logic [31:0]      v2_o;
    logic [TAG_W-1:0] rd_o;
    logic [2:0]       count;

    int checks = 0;
    int errors = 0;

    mul_rs #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush),
        .dispatch_valid_i(dvalid), .dispatch_ready_o(dready),
        .inst_i(inst), .pc_i(pc), .rd_tag_i(rd_tag),
        .rs1_tag_i(t1), .rs2_tag_i(t2),
        .rs1_ready_i(r1), .rs2_ready_i(r2),
        .rs1_value_i(v1), .rs2_value_i(v2),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
        .mul_request_o(req), .inst_o(inst_o), .pc_o(pc_o),
        .rs1_value_o(v1_o), .rs2_value_o(v2_o), .rd_tag_o(rd_o),
        .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dvalid    = 1'b0;
        cdb_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic disp(input logic [31:0] i, input logic [31:0] p, input logic [TAG_W-1:0] rd,
                        input logic [TAG_W-1:0] a_tag, input logic a_rdy, input logic [31:0] a_val,
                        input logic [TAG_W-1:0] b_tag, input logic b_rdy, input logic [31:0] b_val);
        dvalid = 1'b1; inst = i; pc = p; rd_tag = rd;
        t1 = a_tag; r1 = a_rdy; v1 = a_val;
        t2 = b_tag; r2 = b_rdy; v2 = b_val;
    endtask

    task automatic bcast(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    endtask

    initial begin
        reset_ni = 1'b0; flush = 1'b0; dvalid = 1'b0; cdb_valid = 1'b0;
        inst = '0; pc = '0; rd_tag = '0; t1 = '0; t2 = '0; r1 = 1'b0; r2 = 1'b0;
        v1 = '0; v2 = '0; cdb_tag = '0; cdb_value = '0;
        #12;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, dready}, 32'd1);
        chk("rst_inst", inst_o, 32'd0);
        tick();
        reset_ni = 1'b1;
        tick();

        // Both operands ready: issue in the next cycle.
        disp(32'h023100b3, 32'h4, 6'd5, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'hf0000001);
        tick();
        chk("mul_req", {31'd0, req}, 32'd1);
        chk("mul_inst", inst_o, 32'h023100b3);
        chk("mul_pc", pc_o, 32'h4);
        chk("mul_v1", v1_o, 32'h1);
        chk("mul_v2", v2_o, 32'hf0000001);
        chk("mul_rd", {26'd0, rd_o}, 32'd5);
        tick();
        chk("mul_after_req", {31'd0, req}, 32'd0);
        chk("mul_after_count", {29'd0, count}, 32'd0);

        // Wakeup by CDB; no same-cycle CDB-to-issue path.
        disp(32'h023110b3, 32'h8, 6'd6, 6'd7, 1'b0, 32'h0, 6'd3, 1'b1, 32'h2);
        tick();
        chk("mulh_wait_req", {31'd0, req}, 32'd0);
        chk("mulh_wait_count", {29'd0, count}, 32'd1);
        bcast(6'd7, 32'h2);
        #1;
        chk("mulh_cdb_cycle_req", {31'd0, req}, 32'd0);
        tick();
        chk("mulh_req", {31'd0, req}, 32'd1);
        chk("mulh_v1", v1_o, 32'h2);
        chk("mulh_inst", inst_o, 32'h023110b3);
        tick();
        chk("mulh_done_count", {29'd0, count}, 32'd0);

        // Younger ready entry bypasses an older pending one.
        disp(32'h023120b3, 32'h8, 6'd10, 6'd9, 1'b0, 32'h0, 6'd4, 1'b1, 32'h5);
        tick();
        disp(32'h023130b3, 32'hc, 6'd11, 6'd1, 1'b1, 32'h3, 6'd2, 1'b1, 32'h3);
        tick();
        chk("ooo_b_req", {31'd0, req}, 32'd1);
        chk("ooo_b_inst", inst_o, 32'h023130b3);
        chk("ooo_b_pc", pc_o, 32'hc);
        chk("ooo_count2", {29'd0, count}, 32'd2);
        tick();
        chk("ooo_a_wait_req", {31'd0, req}, 32'd0);
        chk("ooo_count1", {29'd0, count}, 32'd1);
        bcast(6'd9, 32'h77);
        tick();
        chk("ooo_a_req", {31'd0, req}, 32'd1);
        chk("ooo_a_inst", inst_o, 32'h023120b3);
        chk("ooo_a_v1", v1_o, 32'h77);
        chk("ooo_a_v2", v2_o, 32'h5);
        chk("ooo_a_rd", {26'd0, rd_o}, 32'd10);
        tick();
        chk("ooo_empty", {29'd0, count}, 32'd0);

        // Dispatch-cycle CDB bypass.
        disp(32'h023100b3, 32'h10, 6'd13, 6'd1, 1'b1, 32'h6, 6'd12, 1'b0, 32'h0);
        bcast(6'd12, 32'h4);
        tick();
        chk("byp_req", {31'd0, req}, 32'd1);
        chk("byp_v2", v2_o, 32'h4);
        chk("byp_v1", v1_o, 32'h6);
        tick();
        chk("byp_empty", {29'd0, count}, 32'd0);

        // Fill to DEPTH with pending entries.
        for (int i = 0; i < 4; i++) begin
            disp(32'h023100b3, 32'h100 + 32'(4 * i), 6'(30 + i), 6'(20 + i), 1'b0, 32'h0,
                 6'd1, 1'b1, 32'(i));
            tick();
        end
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, dready}, 32'd0);
        chk("full_req", {31'd0, req}, 32'd0);
        disp(32'h023100b3, 32'h200, 6'd50, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h1);
        tick();
        chk("full_reject_count", {29'd0, count}, 32'd4);
        chk("full_reject_req", {31'd0, req}, 32'd0);
        bcast(6'd22, 32'haa);
        tick();
        chk("wake2_req", {31'd0, req}, 32'd1);
        chk("wake2_pc", pc_o, 32'h108);
        chk("wake2_v1", v1_o, 32'haa);
        chk("wake2_rd", {26'd0, rd_o}, 32'd32);
        chk("wake2_ready_still0", {31'd0, dready}, 32'd0);
        // Entry 3 is woken while it shifts down to index 2.
        bcast(6'd23, 32'hbb);
        tick();
        chk("compact_count", {29'd0, count}, 32'd3);
        chk("compact_ready", {31'd0, dready}, 32'd1);
        chk("shift_wake_req", {31'd0, req}, 32'd1);
        chk("shift_wake_pc", pc_o, 32'h10c);
        chk("shift_wake_v1", v1_o, 32'hbb);
        chk("shift_wake_v2", v2_o, 32'h3);
        // Simultaneous issue and dispatch keeps count.
        disp(32'h023130b3, 32'h300, 6'd40, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
        tick();
        chk("iss_disp_count", {29'd0, count}, 32'd3);
        chk("iss_disp_req", {31'd0, req}, 32'd1);
        chk("iss_disp_pc", pc_o, 32'h300);
        chk("iss_disp_rd", {26'd0, rd_o}, 32'd40);

        // Flush with a concurrent dispatch.
        disp(32'h023100b3, 32'h400, 6'd41, 6'd1, 1'b1, 32'h9, 6'd2, 1'b1, 32'h9);
        flush = 1'b1;
        #1;
        chk("flush_cycle_req", {31'd0, req}, 32'd0);
        tick();
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_req", {31'd0, req}, 32'd0);
        chk("flush_ready", {31'd0, dready}, 32'd1);
        tick();
        chk("flush_dropped_req", {31'd0, req}, 32'd0);
        chk("flush_dropped_count", {29'd0, count}, 32'd0);

        // Asynchronous reset mid-operation.
        disp(32'h023100b3, 32'h500, 6'd42, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h1);
        tick();
        chk("pre_reset_req", {31'd0, req}, 32'd1);
        reset_ni = 1'b0;
        #1;
        chk("async_reset_req", {31'd0, req}, 32'd0);
        chk("async_reset_count", {29'd0, count}, 32'd0);
        chk("async_reset_pc", pc_o, 32'd0);
        tick();
        reset_ni = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
